alarm_snooze_ctrl: RTL and testbench

Alarm sequencer placed between the clock counter/alarm registers and the buzzer/LED drivers.
- Detects when the running time reaches the stored alarm time.
- Owns the ringing, snooze and dismiss state machine, including a re-arm target and ring timeout.
- Drives buzzer enable and blink LED.
- Replaces ad-hoc alarm flag logic in the top level.

---
 rtl/alarm_snooze_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_alarm_snooze_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_snooze_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_snooze_ctrl
//
// Alarm sequencer between the time-of-day counter / alarm registers and the
// buzzer / LED drivers. It detects the alarm time, runs the
// IDLE -> RINGING -> SNOOZED state machine, tracks the snooze re-arm target
// and the ring timeout, and drives the buzzer enable and blinking LED.
//
// Optional feature (compile-time macro AUTO_SNOOZE_EN):
//   defined     : a ring timeout snoozes automatically while snoozes remain,
//                 otherwise returns to IDLE.
//   not defined : a ring timeout always returns to IDLE.
//
// Parameters:
//   SNOOZE_MIN       minutes added to the current time on snooze (1..59)
//   RING_TIMEOUT_SEC seconds of ringing before automatic stop   (1..255)
//   MAX_SNOOZES      snoozes allowed per alarm event            (1..3)
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-low
//   tick_1hz     one-clk pulse per second
//   alarm_armed  alarm enabled; low forces IDLE
//   adjust_mode  time adjust active; high forces IDLE and blocks triggers
//   cur_hrs/cur_mins/cur_secs  running time of day
//   alarm_hrs/alarm_mins       stored alarm time
//   snooze_btn   debounced one-clk pulse
//   dismiss_btn  debounced one-clk pulse
//   ring         buzzer enable (high exactly while RINGING)
//   led_blink    alarm LED, toggles on every second while RINGING
//   state        0=IDLE, 1=RINGING, 2=SNOOZED
//   snooze_cnt   snoozes used in the current alarm event
//   target_hrs/target_mins     snooze re-arm time
// -----------------------------------------------------------------------------
module alarm_snooze_ctrl #(
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZES      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       alarm_armed,
  input  logic       adjust_mode,
  input  logic [4:0] cur_hrs,
  input  logic [5:0] cur_mins,
  input  logic [5:0] cur_secs,
  input  logic [4:0] alarm_hrs,
  input  logic [5:0] alarm_mins,
  input  logic       snooze_btn,
  input  logic       dismiss_btn,
  output logic       ring,
  output logic       led_blink,
  output logic [1:0] state,
  output logic [1:0] snooze_cnt,
  output logic [4:0] target_hrs,
  output logic [5:0] target_mins
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } state_e;

`ifdef AUTO_SNOOZE_EN
  localparam bit AUTO_SNOOZE = 1'b1;
`else
  localparam bit AUTO_SNOOZE = 1'b0;
`endif

  localparam logic [6:0] SNOOZE_ADD   = 7'(SNOOZE_MIN);
  localparam logic [7:0] TIMEOUT_LAST = 8'(RING_TIMEOUT_SEC - 1);
  localparam logic [1:0] MAX_CNT      = 2'(MAX_SNOOZES);

  state_e     state_q;
  logic [7:0] ring_sec;
  logic       match_q;

  logic       match_a;
  logic       match_s;
  logic       match;
  logic       trigger;
  logic       override;
  logic       can_snooze;
  logic       timeout;

  logic [6:0] mins_sum;
  logic [4:0] snz_hrs;
  logic [5:0] snz_mins;

  assign state = state_q;

  // Alarm / snooze-target comparison; only whole-minute boundaries match.
  assign match_a = (cur_hrs == alarm_hrs)  && (cur_mins == alarm_mins)  && (cur_secs == 6'd0);
  assign match_s = (cur_hrs == target_hrs) && (cur_mins == target_mins) && (cur_secs == 6'd0);

  // The comparison in use depends on what the FSM is waiting for.
  assign match = (state_q == ST_IDLE)    ? match_a :
                 (state_q == ST_SNOOZED) ? match_s : 1'b0;

  // Fire once on the first clk of a matching second, not for every clk of it.
  assign trigger    = match & ~match_q;
  assign override   = adjust_mode | ~alarm_armed;
  assign can_snooze = (snooze_cnt < MAX_CNT);
  assign timeout    = tick_1hz && (ring_sec == TIMEOUT_LAST);

  // Snooze target = current time + SNOOZE_MIN, wrapping minutes into hours
  // and hours at midnight.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    mins_sum = {1'b0, cur_mins} + SNOOZE_ADD;
    snz_mins = mins_sum[5:0];
    snz_hrs  = cur_hrs;
    if (mins_sum >= 7'd60) begin
      snz_mins = 6'(mins_sum - 7'd60);
      snz_hrs  = (cur_hrs == 5'd23) ? 5'd0 : cur_hrs + 5'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and ordering inside the block
  // does not matter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ring        <= 1'b0;
      led_blink   <= 1'b0;
      snooze_cnt  <= 2'd0;
      target_hrs  <= 5'd0;
      target_mins <= 6'd0;
      ring_sec    <= 8'd0;
      // NOTE: match_q comes out of reset high so a time that already equals
      // the alarm right after reset is not seen as a fresh edge.
      match_q     <= 1'b1;
    end else begin
      match_q <= match;

      if (override) begin
        // Target is deliberately held across an override.
        state_q    <= ST_IDLE;
        ring       <= 1'b0;
        led_blink  <= 1'b0;
        snooze_cnt <= 2'd0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (trigger) begin
              state_q   <= ST_RINGING;
              ring      <= 1'b1;
              led_blink <= 1'b1;
              ring_sec  <= 8'd0;
            end
          end

          ST_RINGING: begin
            if (dismiss_btn) begin
              state_q    <= ST_IDLE;
              ring       <= 1'b0;
              led_blink  <= 1'b0;
              snooze_cnt <= 2'd0;
            end else if (timeout) begin
              if (AUTO_SNOOZE && can_snooze) begin
                state_q     <= ST_SNOOZED;
                ring        <= 1'b0;
                led_blink   <= 1'b0;
                snooze_cnt  <= snooze_cnt + 2'd1;
                target_hrs  <= snz_hrs;
                target_mins <= snz_mins;
              end else begin
                state_q    <= ST_IDLE;
                ring       <= 1'b0;
                led_blink  <= 1'b0;
                snooze_cnt <= 2'd0;
              end
            end else if (snooze_btn && can_snooze) begin
              state_q     <= ST_SNOOZED;
              ring        <= 1'b0;
              led_blink   <= 1'b0;
              snooze_cnt  <= snooze_cnt + 2'd1;
              target_hrs  <= snz_hrs;
              target_mins <= snz_mins;
            end else if (tick_1hz) begin
              // A snooze with none left falls through here and keeps ringing.
              led_blink <= ~led_blink;
              ring_sec  <= ring_sec + 8'd1;
            end
          end

          ST_SNOOZED: begin
            if (dismiss_btn) begin
              state_q    <= ST_IDLE;
              ring       <= 1'b0;
              led_blink  <= 1'b0;
              snooze_cnt <= 2'd0;
            end else if (trigger) begin
              state_q   <= ST_RINGING;
              ring      <= 1'b1;
              led_blink <= 1'b1;
              ring_sec  <= 8'd0;
            end
          end

          default: begin
            state_q    <= ST_IDLE;
            ring       <= 1'b0;
            led_blink  <= 1'b0;
            snooze_cnt <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarm_snooze_ctrl
//
// Self-checking bench for alarm_snooze_ctrl with default parameters
// (SNOOZE_MIN=5, RING_TIMEOUT_SEC=60, MAX_SNOOZES=3). A table of one-clk
// vectors covers reset, trigger latency, snooze, midnight wrap and override;
// hand-written sequences cover snooze exhaustion, ring timeout, adjust while
// snoozed and the armed input.
// -----------------------------------------------------------------------------
module tb_alarm_snooze_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz;
  logic       alarm_armed;
  logic       adjust_mode;
  logic [4:0] cur_hrs;
  logic [5:0] cur_mins;
  logic [5:0] cur_secs;
  logic [4:0] alarm_hrs;
  logic [5:0] alarm_mins;
  logic       snooze_btn;
  logic       dismiss_btn;
  logic       ring;
  logic       led_blink;
  logic [1:0] state;
  logic [1:0] snooze_cnt;
  logic [4:0] target_hrs;
  logic [5:0] target_mins;

  int n_tests = 0;
  int n_fail  = 0;

  alarm_snooze_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .alarm_armed (alarm_armed),
    .adjust_mode (adjust_mode),
    .cur_hrs     (cur_hrs),
    .cur_mins    (cur_mins),
    .cur_secs    (cur_secs),
    .alarm_hrs   (alarm_hrs),
    .alarm_mins  (alarm_mins),
    .snooze_btn  (snooze_btn),
    .dismiss_btn (dismiss_btn),
    .ring        (ring),
    .led_blink   (led_blink),
    .state       (state),
    .snooze_cnt  (snooze_cnt),
    .target_hrs  (target_hrs),
    .target_mins (target_mins)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ah, am, armed, adj, ch, cm, cs, tick, snz, dis;
    int e_state, e_ring, e_led, e_cnt, e_th, e_tm;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One clk: inputs set beforehand are sampled at the edge, outputs are
  // looked at 1 time unit later; button/tick pulses last one clk.
  task automatic step();
    @(posedge clk);
    #1;
    tick_1hz    = 1'b0;
    snooze_btn  = 1'b0;
    dismiss_btn = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_hrs  = 5'(h);
    cur_mins = 6'(m);
    cur_secs = 6'(s);
  endtask

  task automatic chk_main(input string tag, input int st, input int rg, input int ld, input int cnt);
    check({tag, ".state"},      32'(state),      32'(st));
    check({tag, ".ring"},       32'(ring),       32'(rg));
    check({tag, ".led_blink"},  32'(led_blink),  32'(ld));
    check({tag, ".snooze_cnt"}, 32'(snooze_cnt), 32'(cnt));
  endtask

  task automatic chk_target(input string tag, input int h, input int m);
    check({tag, ".target_hrs"},  32'(target_hrs),  32'(h));
    check({tag, ".target_mins"}, 32'(target_mins), 32'(m));
  endtask

  // Ring the 07:00 alarm from IDLE: one non-matching clk, then the match.
  task automatic ring_0700(input string tag);
    alarm_hrs  = 5'd7;
    alarm_mins = 6'd0;
    set_time(6, 59, 59); step();
    set_time(7, 0, 0);   step();
    check({tag, ".ringing"}, 32'(state), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            ah  am arm adj  ch  cm  cs tk sz ds | st rg ld cn th tm
    vecs.push_back('{ 7,  0, 1, 0,  7,  0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0}); // no trigger after reset
    vecs.push_back('{ 7,  0, 1, 0, 23, 59, 59, 0, 0, 0,  0, 0, 0, 0, 0, 0});
    vecs.push_back('{ 7,  0, 1, 0,  7,  0,  0, 0, 0, 0,  1, 1, 1, 0, 0, 0}); // next-day match
    vecs.push_back('{ 7,  0, 1, 0,  7,  0,  0, 0, 0, 0,  1, 1, 1, 0, 0, 0});
    vecs.push_back('{ 7,  0, 1, 0,  7,  0,  1, 1, 0, 0,  1, 1, 0, 0, 0, 0}); // blink toggles
    vecs.push_back('{ 7,  0, 1, 0,  7,  0,  2, 1, 0, 0,  1, 1, 1, 0, 0, 0});
    vecs.push_back('{ 7,  0, 1, 0,  7,  0,  3, 1, 0, 0,  1, 1, 0, 0, 0, 0});
    vecs.push_back('{ 7,  0, 1, 0,  7,  0,  3, 0, 1, 0,  2, 0, 0, 1, 7, 5}); // snooze -> 07:05
    vecs.push_back('{ 7,  0, 1, 0,  7,  0,  4, 0, 1, 0,  2, 0, 0, 1, 7, 5}); // snooze ignored
    vecs.push_back('{ 7,  0, 1, 0,  7,  4, 59, 0, 0, 0,  2, 0, 0, 1, 7, 5});
    vecs.push_back('{ 7,  0, 1, 0,  7,  5,  0, 0, 0, 0,  1, 1, 1, 1, 7, 5}); // re-ring
    vecs.push_back('{ 7,  0, 1, 0,  7,  5,  0, 0, 1, 1,  0, 0, 0, 0, 7, 5}); // dismiss beats snooze
    vecs.push_back('{ 7,  0, 1, 0,  7,  5,  0, 0, 0, 0,  0, 0, 0, 0, 7, 5});
    vecs.push_back('{23, 58, 1, 0, 23, 57, 59, 0, 0, 0,  0, 0, 0, 0, 7, 5});
    vecs.push_back('{23, 58, 1, 0, 23, 58,  0, 0, 0, 0,  1, 1, 1, 0, 7, 5});
    vecs.push_back('{23, 58, 1, 0, 23, 58, 30, 0, 1, 0,  2, 0, 0, 1, 0, 3}); // midnight wrap
    vecs.push_back('{23, 58, 1, 0,  0,  2, 59, 0, 0, 0,  2, 0, 0, 1, 0, 3});
    vecs.push_back('{23, 58, 1, 0,  0,  3,  0, 0, 0, 0,  1, 1, 1, 1, 0, 3});
    vecs.push_back('{23, 58, 1, 1,  0,  3,  0, 0, 0, 0,  0, 0, 0, 0, 0, 3}); // adjust override

    rst         = 1'b0;
    tick_1hz    = 1'b0;
    snooze_btn  = 1'b0;
    dismiss_btn = 1'b0;
    alarm_armed = 1'b1;
    adjust_mode = 1'b0;
    alarm_hrs   = 5'd7;
    alarm_mins  = 6'd0;
    set_time(7, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_main("reset", 0, 0, 0, 0);
    chk_target("reset", 0, 0);

    // ---- table-driven vectors ----
    foreach (vecs[i]) begin
      alarm_hrs   = 5'(vecs[i].ah);
      alarm_mins  = 6'(vecs[i].am);
      alarm_armed = 1'(vecs[i].armed);
      adjust_mode = 1'(vecs[i].adj);
      set_time(vecs[i].ch, vecs[i].cm, vecs[i].cs);
      tick_1hz    = 1'(vecs[i].tick);
      snooze_btn  = 1'(vecs[i].snz);
      dismiss_btn = 1'(vecs[i].dis);
      step();
      chk_main($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_ring,
               vecs[i].e_led, vecs[i].e_cnt);
      chk_target($sformatf("vec%0d", i), vecs[i].e_th, vecs[i].e_tm);
    end
    adjust_mode = 1'b0;

    // ---- snooze exhaustion: three snoozes, the fourth is ignored ----
    ring_0700("max");
    for (int i = 0; i < 3; i++) begin
      set_time(7, 5 * i, 10);
      snooze_btn = 1'b1;
      step();
      chk_main($sformatf("max.snz%0d", i), 2, 0, 0, i + 1);
      chk_target($sformatf("max.snz%0d", i), 7, 5 * (i + 1));
      set_time(7, 5 * i + 4, 59); step();
      set_time(7, 5 * i + 5, 0);  step();
      chk_main($sformatf("max.rering%0d", i), 1, 1, 1, i + 1);
    end
    set_time(7, 15, 10);
    snooze_btn = 1'b1;
    step();
    chk_main("max.snz4", 1, 1, 1, 3);
    chk_target("max.snz4", 7, 15);
    dismiss_btn = 1'b1;
    step();
    chk_main("max.dismiss", 0, 0, 0, 0);

    // ---- ring timeout after 60 ticks ----
    ring_0700("tmo");
    set_time(7, 0, 30);
    for (int k = 1; k <= 60; k++) begin
      tick_1hz = 1'b1;
      step();
      if (k < 60) begin
        check($sformatf("tmo.state%0d", k), 32'(state), 32'd1);
        check($sformatf("tmo.led%0d", k), 32'(led_blink), 32'((k % 2) == 0));
      end
      step();
    end
`ifdef AUTO_SNOOZE_EN
    chk_main("tmo.end", 2, 0, 0, 1);
    chk_target("tmo.end", 7, 5);
    dismiss_btn = 1'b1;
    step();
    chk_main("tmo.dismiss", 0, 0, 0, 0);
`else
    chk_main("tmo.end", 0, 0, 0, 0);
`endif

    // ---- adjust while snoozed: back to IDLE, no ring at target ----
    ring_0700("adj");
    set_time(7, 0, 20);
    snooze_btn = 1'b1;
    step();
    chk_main("adj.snz", 2, 0, 0, 1);
    chk_target("adj.snz", 7, 5);
    adjust_mode = 1'b1;
    step();
    chk_main("adj.override", 0, 0, 0, 0);
    chk_target("adj.override", 7, 5);
    adjust_mode = 1'b0;
    set_time(7, 4, 59); step();
    set_time(7, 5, 0);  step();
    chk_main("adj.target", 0, 0, 0, 0);
    step();
    check("adj.after", 32'(state), 32'd0);

    // ---- disarmed: no trigger; arming mid-match does not fire ----
    alarm_armed = 1'b0;
    set_time(6, 59, 59); step();
    set_time(7, 0, 0);   step();
    chk_main("arm.off", 0, 0, 0, 0);
    alarm_armed = 1'b1;
    step();
    check("arm.late", 32'(state), 32'd0);
    set_time(7, 0, 1); step();
    set_time(7, 0, 0); step();
    chk_main("arm.ring", 1, 1, 1, 0);
    alarm_armed = 1'b0;
    step();
    chk_main("arm.drop", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
